fetch_unit: RTL and testbench

- Instruction-fetch front end: owns the PC, fetches words from instruction memory over a req/gnt/rvalid handshake, and presents one instruction at a time to the control unit/decoder with a valid/ack handshake.
- Consumes the decoder's branch decision (PCSrc) and sign-extended immediate (ImmExt) on the ack cycle to select PC+4 or PC+ImmExt.
- At most one memory request is outstanding. Non-compressed RV32I, so fetch addresses are word-aligned.

---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end. Owns the PC, issues one word fetch at a time
//   over a req/gnt/rvalid handshake, and holds the returned instruction for
//   the decoder until it is acknowledged. On the acknowledge cycle the
//   decoder's branch decision picks PC+4 or PC+ImmExt as the next fetch
//   address. A misaligned target parks the unit in a sticky error state that
//   only reset leaves.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   rst         in   synchronous active-high reset
//   mem_req     out  fetch request (high only in REQ, forced low during rst)
//   mem_addr    out  fetch address, always equal to PC
//   mem_gnt     in   memory accepted the request this cycle
//   mem_rvalid  in   read data valid (only honoured while waiting)
//   mem_rdata   in   fetched instruction word
//   instr       out  instruction presented to the decoder
//   instr_valid out  instr is valid and held stable
//   instr_ack   in   decoder consumes instr this cycle
//   PCSrc       in   1 = branch to PC+ImmExt (sampled on ack only)
//   ImmExt      in   branch offset (sampled on ack only)
//   PC          out  address of the instruction presented / being fetched
//   fetch_err   out  sticky misaligned-target error
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  input  logic                  instr_ack,
  input  logic                  PCSrc,
  input  logic [ADDR_WIDTH-1:0] ImmExt,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  fetch_err
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] C_FOUR = ADDR_WIDTH'(4);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [31:0]           r_instr;
  logic                  r_valid;
  logic                  r_err;

  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic                  w_misaligned;

  // Both candidates wrap modulo 2^ADDR_WIDTH; wrap-around is not an error.
  assign w_next_pc    = PCSrc ? (r_pc + ImmExt) : (r_pc + C_FOUR);
  assign w_misaligned = (w_next_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          // Any rvalid seen here is stray and deliberately ignored.
          if (mem_gnt) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_instr <= mem_rdata;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ack) begin
            r_valid <= 1'b0;
            if (w_misaligned) begin
              // PC keeps the address of the offending branch for debug.
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= S_REQ;
            end
          end
        end
        default: begin
          r_state <= S_ERR;
        end
      endcase
    end
  end

  // Request is derived from state, but gated by rst so an in-flight reset
  // never lets a request escape.
  assign mem_req     = (r_state == S_REQ) && !rst;
  assign mem_addr    = r_pc;
  assign PC          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign fetch_err   = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          NCYC   = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] ImmExt = '0;
  logic [31:0] PC;
  logic        fetch_err;

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .PCSrc(PCSrc), .ImmExt(ImmExt), .PC(PC), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_instr  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  // Scoreboard shared between stimulus (push) and monitor (pop).
  logic [31:0] q_addr[$];
  logic [31:0] q_ipc[$];
  logic [31:0] q_iword[$];
  bit          m_err      = 1'b0;
  bit          just_reset = 1'b0;

  task automatic expect_fetch(input logic [31:0] a);
    q_addr.push_back(a);
    q_ipc.push_back(a);
    q_iword.push_back(mem_word(a));
  endtask

  // ---------------- stimulus + reference model ----------------
  initial begin
    logic [31:0] m_pc, paddr, nxt, d_imm;
    bit m_hold, m_req, pending, d_rst, d_ack, d_pcsrc, d_acc, rst_n;
    int pdelay, err_age, sel;
    m_pc = RST_PC; paddr = '0; nxt = '0; d_imm = '0;
    m_hold = 0; m_req = 0; pending = 0;
    d_rst = 1; d_ack = 0; d_pcsrc = 0; d_acc = 0;
    pdelay = 0; err_age = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      // Commit the architectural effect of what was driven in the last cycle.
      if (d_rst) begin
        m_pc = RST_PC; m_err = 0; m_hold = 0; m_req = 1; pending = 0; err_age = 0;
        q_addr.delete(); q_ipc.delete(); q_iword.delete();
        expect_fetch(RST_PC);
        just_reset = 1;
      end else begin
        just_reset = 0;
        if (d_ack && m_hold) begin
          nxt = d_pcsrc ? m_pc + d_imm : m_pc + 32'd4;
          m_hold = 0;
          if ((nxt % 4) != 0) m_err = 1;
          else begin
            m_pc = nxt; m_req = 1;
            expect_fetch(nxt);
          end
        end
        if (d_acc) m_hold = 1;
        if (m_err) err_age++;
      end

      #1;
      rst_n = (cyc < 2) || (m_err && err_age >= 4) || ($urandom_range(0, 149) == 0);
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      instr_ack = 0; PCSrc = 1'($urandom_range(0, 1)); ImmExt = $urandom;
      d_acc = 0;
      if (pending) begin
        if (pdelay == 0) begin
          mem_rvalid = 1; mem_rdata = mem_word(paddr); pending = 0; d_acc = 1;
        end else pdelay--;
      end else begin
        if (m_req && $urandom_range(0, 2) != 0) begin
          mem_gnt = 1; m_req = 0; pending = 1; paddr = m_pc;
          pdelay = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        end
        if ($urandom_range(0, 5) == 0) mem_rvalid = 1;  // stray, must be ignored
      end
      if (m_hold && $urandom_range(0, 2) == 0) begin
        instr_ack = 1;
        sel = $urandom_range(0, 19);
        if (sel == 0) begin
          ImmExt = {ImmExt[31:2], 2'($urandom_range(1, 3))};
        end else if (sel <= 2) begin
          PCSrc = 1; ImmExt = 32'hFFFF_FFFC - m_pc;   // land on the top word
        end else if (sel <= 5) begin
          PCSrc = 1; ImmExt = 32'hFFFF_FFF8;          // backward branch
        end else begin
          ImmExt = 32'($urandom_range(0, 63) - 32) << 2;
        end
      end else if (!m_hold && $urandom_range(0, 4) == 0) begin
        instr_ack = 1;                                 // ack without valid
      end
      rst = rst_n;
      d_rst = rst_n; d_ack = instr_ack; d_pcsrc = PCSrc; d_imm = ImmExt;
    end
    @(negedge clk);
    chk("progress_instr_count_ge_100", 32'(n_instr >= 100), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- monitor ----------------
  bit          mon_prev_valid = 0, mon_wait = 0;
  bit          prev_grant = 0, prev_accept = 0, prev_ack = 0;
  logic [31:0] cur_pc = '0, cur_word = '0;

  always @(negedge clk) begin
    if (rst) begin
      chk("req_during_rst", 32'(mem_req), 32'd0);
      mon_prev_valid = 0; mon_wait = 0;
      prev_grant = 0; prev_accept = 0; prev_ack = 0;
    end else begin
      if (just_reset) begin
        chk("reset_pc", PC, RST_PC);
        chk("reset_instr", instr, 32'd0);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_err", 32'(fetch_err), 32'd0);
        $display("reset released: pc=%h", PC);
      end
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
      if (m_err) begin
        chk("err_req", 32'(mem_req), 32'd0);
        chk("err_valid", 32'(instr_valid), 32'd0);
      end
      if (prev_grant)  chk("req_low_after_gnt", 32'(mem_req), 32'd0);
      if (prev_ack && q_addr.size() != 0) chk("req_after_ack", 32'(mem_req), 32'd1);
      if (prev_accept) chk("valid_after_rvalid", 32'(instr_valid), 32'd1);
      if (mem_req) begin
        if (q_addr.size() == 0) chk("unexpected_req", 32'(mem_req), 32'd0);
        else chk("mem_addr", mem_addr, q_addr[0]);
      end
      if (instr_valid) begin
        if (!mon_prev_valid) begin
          chk("valid_without_rvalid", 32'(prev_accept), 32'd1);
          if (q_ipc.size() == 0) chk("unexpected_valid", 32'(instr_valid), 32'd0);
          else begin
            cur_pc = q_ipc.pop_front();
            cur_word = q_iword.pop_front();
            n_instr++;
            chk("instr", instr, cur_word);
            chk("pc", PC, cur_pc);
            $display("instr pc=%h word=%h", PC, instr);
          end
        end else begin
          chk("instr_hold", instr, cur_word);
          chk("pc_hold", PC, cur_pc);
        end
      end
      prev_grant  = mem_req && mem_gnt;
      prev_accept = mon_wait && mem_rvalid;
      prev_ack    = instr_valid && instr_ack;
      if (prev_grant) begin
        mon_wait = 1;
        if (q_addr.size() != 0) void'(q_addr.pop_front());
      end
      if (prev_accept) mon_wait = 0;
      mon_prev_valid = instr_valid;
    end
  end

endmodule
